// File: rtl/npc_multicycle_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : npc_multicycle_ctrl
// Description : Multi-cycle sequencer for the NPC core. Owns the PC and runs
//               each instruction through fetch / execute / memory / commit
//               using valid-ready handshakes toward the IFU and LSU, with
//               sticky halt and fault (fetch error, LSU error, timeout)
//               handling and a retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module npc_multicycle_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
    parameter int              TIMEOUT  = 255,
    parameter int              CNT_W    = 64
) (
    input  logic             clk,
    input  logic             rst,

    // instruction fetch port
    output logic             ifu_req_valid,
    input  logic             ifu_req_ready,
    output logic [XLEN-1:0]  ifu_req_addr,
    input  logic             ifu_rsp_valid,
    input  logic [XLEN-1:0]  ifu_rsp_inst,
    input  logic             ifu_rsp_err,

    // load/store port
    output logic             lsu_req_valid,
    input  logic             lsu_req_ready,
    input  logic             lsu_rsp_valid,
    input  logic             lsu_rsp_err,

    // decoder / EXU side
    input  logic             dec_mem_ren,
    input  logic             dec_mem_wen,
    input  logic             halt_req,
    input  logic [XLEN-1:0]  npc,

    // architectural state and status
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  inst,
    output logic             inst_valid,
    output logic             wb_en,
    output logic             done,
    output logic             halted,
    output logic             fault,
    output logic [1:0]       fault_cause,
    output logic [CNT_W-1:0] retire_cnt
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] C_CAUSE_NONE  = 2'b00;
    localparam logic [1:0] C_CAUSE_FETCH = 2'b01;
    localparam logic [1:0] C_CAUSE_LSU   = 2'b10;
    localparam logic [1:0] C_CAUSE_TMO   = 2'b11;

    // The wait counter only has to reach TIMEOUT-1: the cycle in which it
    // holds that value is the TIMEOUT-th cycle spent waiting.
    localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] C_TMO_LAST = (TIMEOUT > 0) ? TMO_W'(TIMEOUT - 1)
                                                            : '0;
    localparam logic C_TMO_EN = (TIMEOUT > 0);

    typedef enum logic [3:0] {
        S_RESET_WAIT = 4'd0,
        S_FETCH_REQ  = 4'd1,
        S_FETCH_WAIT = 4'd2,
        S_EXEC       = 4'd3,
        S_MEM_REQ    = 4'd4,
        S_MEM_WAIT   = 4'd5,
        S_COMMIT     = 4'd6,
        S_HALT       = 4'd7,
        S_FAULT      = 4'd8
    } state_t;

    state_t           r_state;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             w_tmo_hit;
    logic             w_mem_op;

    // The fetch address is the PC itself; the PC only moves in COMMIT, so it
    // cannot change while a fetch request is pending.
    assign ifu_req_addr = pc;

    // Wait-state budget exhausted in the current cycle
    assign w_tmo_hit = C_TMO_EN && (r_tmo_cnt == C_TMO_LAST);

    // Instruction needs the LSU
    assign w_mem_op = dec_mem_ren | dec_mem_wen;

    // Sequencer: state, PC, instruction latch, counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_RESET_WAIT;
            r_tmo_cnt     <= '0;
            pc            <= RESET_PC;
            inst          <= '0;
            inst_valid    <= 1'b0;
            ifu_req_valid <= 1'b0;
            lsu_req_valid <= 1'b0;
            wb_en         <= 1'b0;
            done          <= 1'b0;
            halted        <= 1'b0;
            fault         <= 1'b0;
            fault_cause   <= C_CAUSE_NONE;
            retire_cnt    <= '0;
        end else begin
            // commit strobes are single-cycle unless COMMIT is entered again
            wb_en <= 1'b0;
            done  <= 1'b0;

            case (r_state)
                S_RESET_WAIT: begin
                    r_state       <= S_FETCH_REQ;
                    ifu_req_valid <= 1'b1;
                end

                // hold the request until the IFU accepts it; responses ignored
                S_FETCH_REQ: begin
                    if (ifu_req_ready) begin
                        ifu_req_valid <= 1'b0;
                        r_tmo_cnt     <= '0;
                        r_state       <= S_FETCH_WAIT;
                    end
                end

                // a response wins over a timeout in the same cycle
                S_FETCH_WAIT: begin
                    if (ifu_rsp_valid) begin
                        if (ifu_rsp_err) begin
                            fault       <= 1'b1;
                            fault_cause <= C_CAUSE_FETCH;
                            r_state     <= S_FAULT;
                        end else begin
                            inst       <= ifu_rsp_inst;
                            inst_valid <= 1'b1;
                            r_state    <= S_EXEC;
                        end
                    end else if (w_tmo_hit) begin
                        fault       <= 1'b1;
                        fault_cause <= C_CAUSE_TMO;
                        r_state     <= S_FAULT;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
                end

                // decoder outputs are valid here because inst is stable
                S_EXEC: begin
                    if (w_mem_op) begin
                        lsu_req_valid <= 1'b1;
                        r_state       <= S_MEM_REQ;
                    end else begin
                        wb_en   <= 1'b1;
                        done    <= 1'b1;
                        r_state <= S_COMMIT;
                    end
                end

                S_MEM_REQ: begin
                    if (lsu_req_ready) begin
                        lsu_req_valid <= 1'b0;
                        r_tmo_cnt     <= '0;
                        r_state       <= S_MEM_WAIT;
                    end
                end

                S_MEM_WAIT: begin
                    if (lsu_rsp_valid) begin
                        if (lsu_rsp_err) begin
                            inst_valid  <= 1'b0;
                            fault       <= 1'b1;
                            fault_cause <= C_CAUSE_LSU;
                            r_state     <= S_FAULT;
                        end else begin
                            wb_en   <= 1'b1;
                            done    <= 1'b1;
                            r_state <= S_COMMIT;
                        end
                    end else if (w_tmo_hit) begin
                        inst_valid  <= 1'b0;
                        fault       <= 1'b1;
                        fault_cause <= C_CAUSE_TMO;
                        r_state     <= S_FAULT;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
                end

                // architectural update; halt_req is only looked at here
                S_COMMIT: begin
                    pc         <= npc;
                    retire_cnt <= retire_cnt + CNT_W'(1);
                    inst_valid <= 1'b0;
                    if (halt_req) begin
                        halted  <= 1'b1;
                        r_state <= S_HALT;
                    end else begin
                        ifu_req_valid <= 1'b1;
                        r_state       <= S_FETCH_REQ;
                    end
                end

                // terminal states: only reset leaves them
                S_HALT:  r_state <= S_HALT;
                S_FAULT: r_state <= S_FAULT;

                // unreachable encodings park in FAULT with everything quiet
                default: begin
                    ifu_req_valid <= 1'b0;
                    lsu_req_valid <= 1'b0;
                    inst_valid    <= 1'b0;
                    fault         <= 1'b1;
                    r_state       <= S_FAULT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_npc_multicycle_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_npc_multicycle_ctrl
// Description : Directed self-checking bench for npc_multicycle_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_npc_multicycle_ctrl;

    localparam logic [31:0] C_BASE = 32'h8000_0000;
    localparam logic [31:0] C_INST = 32'h0010_0093;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
    logic [31:0] ifu_req_addr, ifu_rsp_inst;
    logic        lsu_req_valid, lsu_req_ready, lsu_rsp_valid, lsu_rsp_err;
    logic        dec_mem_ren, dec_mem_wen, halt_req;
    logic [31:0] npc, pc, inst;
    logic        inst_valid, wb_en, done, halted, fault;
    logic [1:0]  fault_cause;
    logic [63:0] retire_cnt;

    int total = 0;
    int bad   = 0;

    npc_multicycle_ctrl #(
        .XLEN     (32),
        .RESET_PC (32'h8000_0000),
        .TIMEOUT  (4),
        .CNT_W    (64)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_req_addr  (ifu_req_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_inst  (ifu_rsp_inst),
        .ifu_rsp_err   (ifu_rsp_err),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_err   (lsu_rsp_err),
        .dec_mem_ren   (dec_mem_ren),
        .dec_mem_wen   (dec_mem_wen),
        .halt_req      (halt_req),
        .npc           (npc),
        .pc            (pc),
        .inst          (inst),
        .inst_valid    (inst_valid),
        .wb_en         (wb_en),
        .done          (done),
        .halted        (halted),
        .fault         (fault),
        .fault_cause   (fault_cause),
        .retire_cnt    (retire_cnt)
    );

    // simple EXU: sequential next PC
    assign npc = pc + 32'h4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // advance one cycle and sample just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b0;
        ifu_req_ready = 1'b1;
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = C_INST;
        ifu_rsp_err   = 1'b0;
        lsu_req_ready = 1'b1;
        lsu_rsp_valid = 1'b1;
        lsu_rsp_err   = 1'b0;
        dec_mem_ren   = 1'b0;
        dec_mem_wen   = 1'b0;
        halt_req      = 1'b0;

        // ---------------- reset state ----------------
        step(); step();
        chk("rst_pc",     pc,            C_BASE);
        chk("rst_ifuv",   ifu_req_valid, 1'b0);
        chk("rst_inst",   inst,          32'h0);
        chk("rst_status", {inst_valid, wb_en, done, halted, fault, fault_cause}, 7'b0);
        chk("rst_retire", retire_cnt,    64'd0);

        // ---------------- three non-memory instructions, zero delay ----------------
        rst = 1'b1;
        step();                                         // cycle 1
        chk("first_req_valid", ifu_req_valid, 1'b1);
        chk("first_req_addr",  ifu_req_addr,  C_BASE);
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) step();
            chk($sformatf("done_c%0d", c), done, (c % 4) == 0);
            if (c == 3) begin
                chk("exec_inst",  inst,       C_INST);
                chk("exec_ivld",  inst_valid, 1'b1);
            end
            if (c == 4) chk("commit_wb", wb_en, 1'b1);
        end
        step();                                         // cycle 13, FETCH_REQ
        chk("t1_retire", retire_cnt, 64'd3);
        chk("t1_pc",     pc,         C_BASE + 32'hC);

        // ---------------- fetch request held off for 5 cycles ----------------
        ifu_req_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin                // cycles 13..17
            chk($sformatf("stall_valid_%0d", k), ifu_req_valid, 1'b1);
            chk($sformatf("stall_addr_%0d", k),  ifu_req_addr,  C_BASE + 32'hC);
            step();
        end
        ifu_req_ready = 1'b1;                           // cycle 18
        chk("stall_valid_end", ifu_req_valid, 1'b1);
        step(); step();                                 // cycle 20 EXEC
        chk("stall_no_early_done", done, 1'b0);
        step();                                         // cycle 21 COMMIT
        chk("stall_done", done, 1'b1);
        step();                                         // cycle 22 FETCH_REQ
        chk("stall_pc",     pc,         C_BASE + 32'h10);
        chk("stall_retire", retire_cnt, 64'd4);

        // ---------------- store with LSU error at 0x8000_0010 ----------------
        dec_mem_wen = 1'b1;
        lsu_rsp_err = 1'b1;
        step(); step(); step();                         // cycle 25 MEM_REQ
        chk("st_lsu_valid", lsu_req_valid, 1'b1);
        chk("st_no_done",   done,          1'b0);
        step();                                         // cycle 26 MEM_WAIT
        chk("st_lsu_drop",  lsu_req_valid, 1'b0);
        step();                                         // cycle 27 FAULT
        chk("st_fault",     fault,       1'b1);
        chk("st_cause",     fault_cause, 2'b10);
        chk("st_pc",        pc,          C_BASE + 32'h10);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("st_quiet_%0d", k), {wb_en, done, ifu_req_valid, lsu_req_valid}, 4'b0);
            step();
        end
        chk("st_retire_held", retire_cnt, 64'd4);

        // ---------------- reset clears a faulted core asynchronously ----------------
        rst = 1'b0;
        #1;
        chk("arst_fault", {fault, fault_cause}, 3'b0);
        chk("arst_pc",    pc,         C_BASE);
        chk("arst_cnt",   retire_cnt, 64'd0);
        dec_mem_wen   = 1'b0;
        lsu_rsp_err   = 1'b0;
        dec_mem_ren   = 1'b1;
        lsu_rsp_valid = 1'b0;
        step(); step();
        chk("arst_noreq", ifu_req_valid, 1'b0);

        // ---------------- load with response 3 cycles late ----------------
        rst = 1'b1;
        step(); step(); step(); step();                 // cycle 4 MEM_REQ
        chk("ld_req", lsu_req_valid, 1'b1);
        for (int c = 5; c <= 8; c++) begin               // MEM_WAIT 5..8
            step();
            chk($sformatf("ld_wait_%0d", c), {lsu_req_valid, wb_en, inst_valid}, 3'b001);
        end
        lsu_rsp_valid = 1'b1;
        dec_mem_ren   = 1'b0;
        step();                                         // cycle 9 COMMIT
        chk("ld_wb",   {wb_en, done, fault}, 3'b110);
        step();                                         // cycle 10 FETCH_REQ
        chk("ld_wb_once", wb_en,      1'b0);
        chk("ld_pc",      pc,         C_BASE + 32'h4);
        chk("ld_retire",  retire_cnt, 64'd1);

        // ---------------- ebreak halts after one commit ----------------
        halt_req = 1'b1;
        step(); step(); step();                         // cycle 13 COMMIT
        chk("halt_done", done, 1'b1);
        step();
        chk("halt_flag",   halted,     1'b1);
        chk("halt_pc",     pc,         C_BASE + 32'h8);
        chk("halt_retire", retire_cnt, 64'd2);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("halt_quiet_%0d", k), {ifu_req_valid, done, lsu_req_valid}, 3'b0);
        end

        // ---------------- reset mid-fetch ----------------
        rst = 1'b0;
        halt_req = 1'b0;
        step();
        rst = 1'b1;
        step(); step(); step(); step();                 // cycle 4 COMMIT
        step();                                         // cycle 5 FETCH_REQ
        chk("mf_pre_pc",  pc,         C_BASE + 32'h4);
        chk("mf_pre_cnt", retire_cnt, 64'd1);
        ifu_rsp_valid = 1'b0;
        step();                                         // cycle 6 FETCH_WAIT
        rst = 1'b0;
        ifu_rsp_valid = 1'b1;                           // stale response during reset
        #1;
        chk("mf_pc",  pc,         C_BASE);
        chk("mf_cnt", retire_cnt, 64'd0);
        step(); step();
        chk("mf_idle", {ifu_req_valid, inst_valid, done}, 3'b0);

        // ---------------- fetch timeout (TIMEOUT=4) ----------------
        rst = 1'b1;
        step();                                         // cycle 1 FETCH_REQ
        chk("to_req_addr", ifu_req_addr, C_BASE);
        ifu_rsp_valid = 1'b0;
        for (int c = 2; c <= 5; c++) begin               // FETCH_WAIT 2..5
            step();
            chk($sformatf("to_wait_%0d", c), {fault, ifu_req_valid, inst_valid}, 3'b000);
        end
        step();                                         // cycle 6
        chk("to_fault", fault,       1'b1);
        chk("to_cause", fault_cause, 2'b11);
        chk("to_pc",    pc,          C_BASE);
        chk("to_nodone", {done, wb_en, retire_cnt}, 66'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/npc_multicycle_ctrl.md
# npc_multicycle_ctrl

Parametrised multi-cycle sequencer for the NPC core. It replaces the fixed fetch/execute toggle with an explicit state machine. The machine drives valid/ready request/response handshakes to the instruction and data memory ports, so memory latency can vary. It also handles halt, memory-error and timeout faults, and keeps a retired-instruction counter. It sits at the core top, owns the PC, and gates the decoder, the LSU and register write-back.

## Interface

Parameters:
- XLEN, 32, datapath/address width
- RESET_PC, 32'h8000_0000, PC value loaded on reset
- TIMEOUT, 255, maximum cycles spent in any WAIT state before a fault; 0 disables the timeout
- CNT_W, 64, retire counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous assert, active-low; releases synchronously to clk
- ifu_req_valid  out  1  fetch request
- ifu_req_ready  in  1  fetch request accepted
- ifu_req_addr  out  XLEN  fetch address, always equal to pc
- ifu_rsp_valid  in  1  fetch data valid
- ifu_rsp_inst  in  XLEN  fetched instruction
- ifu_rsp_err  in  1  fetch bus error, qualified by ifu_rsp_valid
- lsu_req_valid  out  1  load/store request
- lsu_req_ready  in  1  LSU request accepted
- lsu_rsp_valid  in  1  load data valid / store acknowledged
- lsu_rsp_err  in  1  LSU bus error, qualified by lsu_rsp_valid
- dec_mem_ren, dec_mem_wen  in  1  from the decoder; meaningful while inst_valid=1
- halt_req  in  1  from the decoder (ebreak)
- npc  in  XLEN  next PC from the EXU
- pc  out  XLEN  current PC
- inst  out  XLEN  latched instruction
- inst_valid  out  1  inst is held for the current instruction
- wb_en  out  1  single-cycle commit strobe that gates GPR/CSR writes
- done  out  1  single-cycle commit strobe exported to the simulator
- halted  out  1  sticky halt
- fault  out  1  sticky fault
- fault_cause  out  2  01 = fetch error, 10 = load/store error, 11 = timeout
- retire_cnt  out  CNT_W  number of committed instructions

## Operation

- States: RESET_WAIT, FETCH_REQ, FETCH_WAIT, EXEC, MEM_REQ, MEM_WAIT, COMMIT, HALT, FAULT.
- RESET_WAIT: all outputs idle; moves to FETCH_REQ on the first clk edge with rst high.
- FETCH_REQ: ifu_req_valid=1.
  - ifu_req_ready=1 -> FETCH_WAIT.
  - ifu_rsp_valid is ignored in this state.
- FETCH_WAIT:
  - ifu_rsp_valid with err=0: latch inst, then EXEC.
  - ifu_rsp_valid with err=1: FAULT, cause 01.
- EXEC: inst_valid=1 for one cycle while decode settles. Next state:
  - dec_mem_ren or dec_mem_wen set -> MEM_REQ.
  - otherwise -> COMMIT.
- MEM_REQ: lsu_req_valid=1 until lsu_req_ready, then MEM_WAIT.
- MEM_WAIT:
  - lsu_rsp_valid with err=0 -> COMMIT.
  - lsu_rsp_valid with err=1 -> FAULT, cause 10.
- COMMIT:
  - wb_en=1 and done=1 for exactly one cycle.
  - pc<=npc and retire_cnt+=1.
  - halt_req=1 -> HALT; otherwise -> FETCH_REQ.
- inst_valid=1 from EXEC through COMMIT inclusive. inst is held stable, so decoder outputs stay stable for the whole instruction.
- halt_req is sampled only in COMMIT.
- HALT is terminal: halted=1, no requests issued, pc frozen at the address of the halting instruction's npc.
- FAULT is terminal: fault=1, fault_cause held, pc frozen at the faulting instruction, no commit.
- Timeout: counter cleared on entry to each WAIT state and incremented every cycle spent there. When it reaches TIMEOUT -> FAULT, cause 11.
- Responses arriving in non-WAIT states are dropped, including stale ones after a reset.
- retire_cnt wraps modulo 2^CNT_W.

## Timing

- Reset values: pc=RESET_PC, inst=0, all strobes, valids, halted and fault=0, fault_cause=0, retire_cnt=0, state=RESET_WAIT.
- Reset asserted mid-instruction: all state clears immediately. No commit occurs, and no request is reissued until RESET_WAIT exits.
- ifu_req_valid stays high until accepted. ifu_req_addr does not change while the request is pending. The same rules apply to the LSU request.
- Minimum latency, with ready in the request cycle and response in the next cycle:
  - non-memory instruction: 4 cycles (FETCH_REQ, FETCH_WAIT, EXEC, COMMIT);
  - load/store: 6 cycles.
- Each cycle of ready or response delay adds one cycle.
- The first ifu_req_valid appears 1 cycle after rst deasserts.
- done and wb_en are never high in the same cycle as any request valid.

## Test plan

- Reset release with zero-delay memories and 3 non-memory instructions:
  - first ifu_req_addr = 0x8000_0000, one cycle after release;
  - done pulses at cycles 4, 8 and 12;
  - retire_cnt = 3.
- ifu_req_ready held low for 5 cycles:
  - ifu_req_valid and address stay stable throughout;
  - the commit slips by exactly 5 cycles.
- Load with lsu_rsp_valid arriving 3 cycles late: MEM_WAIT lasts 4 cycles, wb_en pulses once, pc = npc afterwards.
- lsu_rsp_err=1 on a store at pc 0x8000_0010:
  - fault=1, cause=10, pc stays 0x8000_0010;
  - no wb_en pulse and no further requests.
- TIMEOUT=4 with ifu_rsp_valid never asserted: FAULT with cause 11 after 4 cycles in FETCH_WAIT.
- ebreak with halt_req=1: one done pulse, then halted=1 and ifu_req_valid stays 0. Asserting rst low mid-fetch then returns pc to 0x8000_0000 and retire_cnt to 0.
